multi_phase_traffic_ctrl: RTL and testbench
===========================================

MULTI_PHASE_TRAFFIC_CTRL -- requirements
Module: multi_phase_traffic_ctrl

Interface
REQ-001 SHALL have parameter N_ROADS, default 4, number of approaches (2..8); road 0 is the primary road.
REQ-002 SHALL have parameter TICK_DIV, default 10_000_000, clk cycles per timing tick (1 s at 10 MHz).
REQ-003 SHALL have parameters GREEN_MIN=10, SEC_GREEN=8, YELLOW=3, ALL_RED=1, each a duration in ticks (>=1).
REQ-004 clk  input  1  system clock (10 MHz nominal).
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 fault  input  1  asynchronous system fault request, active-high.
REQ-007 sensor  input  N_ROADS  per-road vehicle-waiting sensor, asynchronous; bit 0 ignored.
REQ-008 light_RYG  output  3*N_ROADS  road i on bits [3i+2:3i] = {R,Y,G}, registered.
REQ-009 active_road  output  3  index of the road currently holding right-of-way, registered.
REQ-010 fault_active  output  1  high while in FLASH, registered.

Function
REQ-011 fault and sensor SHALL each pass a 2-flop synchroniser; all logic uses the synchronised copies (2-cycle input latency).
REQ-012 A synchronised sensor[i] (i>=1) SHALL set sticky demand[i]; demand[i] clears on the cycle road i enters GREEN; set and clear in the same cycle -> clear wins.
REQ-013 States: GREEN, YELLOW, ALL_RED, FLASH; cur road index held in register.
REQ-014 Prescaler SHALL restart at 0 on every state entry; a tick occurs every TICK_DIV cycles; a state of duration T lasts exactly T*TICK_DIV cycles.
REQ-015 GREEN, cur=0: after GREEN_MIN ticks, SHALL go to YELLOW on the first cycle any demand[1..N_ROADS-1] is set; with no demand stays indefinitely.
REQ-016 GREEN, cur!=0: SHALL go to YELLOW after SEC_GREEN ticks regardless of demand.
REQ-017 YELLOW SHALL last YELLOW ticks then go to ALL_RED; ALL_RED SHALL last ALL_RED ticks then enter GREEN on the next road.
REQ-018 Next road: round-robin search of demand starting at cur+1, wrapping from N_ROADS-1 to 1, road 0 skipped; no demand -> road 0.
REQ-019 Next road SHALL be sampled on the last cycle of ALL_RED.
REQ-020 Lights: GREEN -> cur road 001, others 100; YELLOW -> cur road 010, others 100; ALL_RED -> all 100.
REQ-021 Synchronised fault high SHALL enter FLASH on the next clk edge from any state; demand register retained.
REQ-022 FLASH: phase flag set on entry, toggles every tick; phase=1 -> road 0 010, others 100; phase=0 -> all 000.
REQ-023 Synchronised fault low in FLASH SHALL enter ALL_RED (ALL_RED ticks), then GREEN on road 0 with minimum timer restarted.
REQ-024 fault has priority over every other transition, including same-cycle timer expiry.
REQ-025 active_road SHALL equal cur in all states; 0 in FLASH.
REQ-026 No two roads SHALL ever show G or Y simultaneously; any G->R change passes through Y then all-red.

Reset
REQ-027 On reset: state GREEN, cur=0, prescaler/timer/min_done 0, demand 0, synchronisers 0, phase 0.
REQ-028 Reset outputs: light_RYG road 0 = 001, others 100; active_road=0; fault_active=0.
REQ-029 Reset asserted mid-sequence SHALL force reset values immediately; deassertion restarts GREEN_MIN timing.

Structure
REQ-030 Shared package tl_pkg SHALL hold state encoding and RYG constants (RED=100, YEL=010, GRN=001, OFF=000).
REQ-031 Prescaler plus tick-count timer SHALL be one sub-module tl_tick_timer (load, duration, tick, done).
REQ-032 Round-robin next-road selection SHALL be a combinational function in the top module.

Verification (N_ROADS=4, TICK_DIV=4, GREEN_MIN=3, SEC_GREEN=2, YELLOW=2, ALL_RED=1)
REQ-033 No sensors, 200 cycles after reset -> light_RYG stays 100_100_100_001, active_road=0.
REQ-034 sensor[2] pulse 1 cycle at cycle 5 -> road 0 Y at cycle 12, all-red at 20, road 2 G at 24 for 8 cycles, Y 8, all-red 4, road 0 G.
REQ-035 sensor[1] and sensor[3] held from reset -> green order 0,1,3,1,3,...; road 0 green only when demand empty.
REQ-036 fault high during road 3 GREEN -> FLASH 3 cycles later, road 0 toggling 010/000 every 4 cycles, others 100/000, fault_active=1.
REQ-037 fault low in FLASH -> all-red 4 cycles, then road 0 G, held at least 12 cycles even with demand pending.
REQ-038 reset pulse during YELLOW -> next cycle outputs equal reset values; sensor[1] raised same cycle as entering road 1 GREEN -> demand[1] clear.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared state encoding, lamp codes and timer width for the traffic controller.
package tl_pkg;

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_ALL_RED = 2'd2,
    ST_FLASH   = 2'd3
  } tl_state_e;

  // Lamp codes per road, ordered {R,Y,G}
  localparam logic [2:0] RYG_RED = 3'b100;
  localparam logic [2:0] RYG_YEL = 3'b010;
  localparam logic [2:0] RYG_GRN = 3'b001;
  localparam logic [2:0] RYG_OFF = 3'b000;

  localparam int unsigned DUR_W = 16;

endpackage

// File: rtl/tl_tick_timer.sv
// Prescaler plus tick counter; load restarts both, done marks the last cycle of a duration.
module tl_tick_timer
  import tl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] duration,
  output logic             tick,
  output logic             done
);

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PS_W-1:0]  prescale_q, prescale_d;
  logic [DUR_W-1:0] count_q, count_d;

  assign tick = (prescale_q == PS_W'(TICK_DIV - 1));
  // Count holds at duration-1 once reached, so done re-pulses on every later tick.
  assign done = tick && (count_q == duration - DUR_W'(1));

  always_comb begin
    prescale_d = tick ? '0 : prescale_q + PS_W'(1);
    count_d    = count_q;
    if (tick && !done) count_d = count_q + DUR_W'(1);
    if (load) begin
      prescale_d = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      count_q    <= '0;
    end else begin
      prescale_q <= prescale_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-approach traffic light controller: primary road 0 rests green, side roads
// are served round-robin on demand, and a fault request forces a flashing mode.
module multi_phase_traffic_ctrl
  import tl_pkg::*;
#(
  parameter int unsigned N_ROADS   = 4,
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned GREEN_MIN = 10,
  parameter int unsigned SEC_GREEN = 8,
  parameter int unsigned YELLOW    = 3,
  parameter int unsigned ALL_RED   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fault,
  input  logic [N_ROADS-1:0]     sensor,
  output logic [3*N_ROADS-1:0]   light_RYG,
  output logic [2:0]             active_road,
  output logic                   fault_active
);

  function automatic logic [2:0] next_road(input logic [2:0] cur, input logic [N_ROADS-1:0] dem);
    logic [2:0] sel;
    logic       found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i < N_ROADS; i++)
      if (!found && dem[i] && (i > 32'(cur))) begin
        sel   = 3'(i);
        found = 1'b1;
      end
    for (int unsigned i = 1; i < N_ROADS; i++)
      if (!found && dem[i]) begin
        sel   = 3'(i);
        found = 1'b1;
      end
    return sel;
  endfunction

  function automatic logic [3*N_ROADS-1:0] lights_for(input tl_state_e st, input logic [2:0] cur,
                                                       input logic phase);
    logic [3*N_ROADS-1:0] l;
    l = '0;
    for (int unsigned i = 0; i < N_ROADS; i++) begin
      case (st)
        ST_GREEN:   l[3*i +: 3] = (3'(i) == cur) ? RYG_GRN : RYG_RED;
        ST_YELLOW:  l[3*i +: 3] = (3'(i) == cur) ? RYG_YEL : RYG_RED;
        ST_ALL_RED: l[3*i +: 3] = RYG_RED;
        default:    l[3*i +: 3] = !phase ? RYG_OFF : ((i == 0) ? RYG_YEL : RYG_RED);
      endcase
    end
    return l;
  endfunction

  logic                 fault_s1_q, fault_s2_q;
  logic [N_ROADS-1:0]   sensor_s1_q, sensor_s2_q;
  tl_state_e            state_q, state_d;
  logic [2:0]           cur_q, cur_d;
  logic [N_ROADS-1:0]   demand_q, demand_d, clr_mask;
  logic                 min_done_q, min_done_d;
  logic                 phase_q, phase_d;
  logic                 recover_q, recover_d;
  logic [3*N_ROADS-1:0] light_q, light_d;
  logic [2:0]           active_q;
  logic                 fault_active_q;
  logic                 load, tick, done, any_demand;
  logic [DUR_W-1:0]     duration;

  assign any_demand = |demand_q;

  always_comb begin
    case (state_q)
      ST_GREEN:   duration = (cur_q == '0) ? DUR_W'(GREEN_MIN) : DUR_W'(SEC_GREEN);
      ST_YELLOW:  duration = DUR_W'(YELLOW);
      ST_ALL_RED: duration = DUR_W'(ALL_RED);
      default:    duration = DUR_W'(1);
    endcase
  end

  tl_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk      (clk),
    .rst      (reset),
    .load     (load),
    .duration (duration),
    .tick     (tick),
    .done     (done)
  );

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    min_done_d = min_done_q;
    phase_d    = phase_q;
    recover_d  = recover_q;
    load       = 1'b0;
    clr_mask   = '0;
    if (fault_s2_q) begin
      if (state_q != ST_FLASH) begin
        state_d = ST_FLASH;
        cur_d   = '0;
        phase_d = 1'b1;
        load    = 1'b1;
      end else if (tick) begin
        phase_d = ~phase_q;
      end
    end else begin
      case (state_q)
        ST_GREEN: begin
          if (cur_q == '0) begin
            if (done) min_done_d = 1'b1;
            if ((min_done_q || done) && any_demand) begin
              state_d = ST_YELLOW;
              load    = 1'b1;
            end
          end else if (done) begin
            state_d = ST_YELLOW;
            load    = 1'b1;
          end
        end
        ST_YELLOW: begin
          if (done) begin
            state_d = ST_ALL_RED;
            load    = 1'b1;
          end
        end
        ST_ALL_RED: begin
          if (done) begin
            // Leaving a fault recovery always returns to the primary road.
            state_d    = ST_GREEN;
            load       = 1'b1;
            min_done_d = 1'b0;
            recover_d  = 1'b0;
            cur_d      = recover_q ? 3'd0 : next_road(cur_q, demand_q);
            clr_mask   = N_ROADS'(1) << cur_d;
          end
        end
        default: begin
          state_d   = ST_ALL_RED;
          load      = 1'b1;
          recover_d = 1'b1;
          phase_d   = 1'b0;
        end
      endcase
    end
    demand_d = (demand_q | (sensor_s2_q & ~N_ROADS'(1))) & ~clr_mask;
    light_d  = lights_for(state_d, cur_d, phase_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_s1_q     <= 1'b0;
      fault_s2_q     <= 1'b0;
      sensor_s1_q    <= '0;
      sensor_s2_q    <= '0;
      state_q        <= ST_GREEN;
      cur_q          <= '0;
      demand_q       <= '0;
      min_done_q     <= 1'b0;
      phase_q        <= 1'b0;
      recover_q      <= 1'b0;
      light_q        <= lights_for(ST_GREEN, 3'd0, 1'b0);
      active_q       <= '0;
      fault_active_q <= 1'b0;
    end else begin
      fault_s1_q     <= fault;
      fault_s2_q     <= fault_s1_q;
      sensor_s1_q    <= sensor;
      sensor_s2_q    <= sensor_s1_q;
      state_q        <= state_d;
      cur_q          <= cur_d;
      demand_q       <= demand_d;
      min_done_q     <= min_done_d;
      phase_q        <= phase_d;
      recover_q      <= recover_d;
      light_q        <= light_d;
      active_q       <= cur_d;
      fault_active_q <= (state_d == ST_FLASH);
    end
  end

  assign light_RYG    = light_q;
  assign active_road  = active_q;
  assign fault_active = fault_active_q;

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Directed bench for multi_phase_traffic_ctrl with N_ROADS=4, TICK_DIV=4, GREEN_MIN=3,
// SEC_GREEN=2, YELLOW=2, ALL_RED=1; cycle 0 is the first cycle after reset release.
module tb_multi_phase_traffic_ctrl;

  localparam logic [11:0] L_R0G  = 12'b100_100_100_001;
  localparam logic [11:0] L_R0Y  = 12'b100_100_100_010;
  localparam logic [11:0] L_ALLR = 12'b100_100_100_100;
  localparam logic [11:0] L_R1G  = 12'b100_100_001_100;
  localparam logic [11:0] L_R1Y  = 12'b100_100_010_100;
  localparam logic [11:0] L_R2G  = 12'b100_001_100_100;
  localparam logic [11:0] L_R3G  = 12'b001_100_100_100;
  localparam logic [11:0] L_R3Y  = 12'b010_100_100_100;
  localparam logic [11:0] L_FL1  = 12'b100_100_100_010;
  localparam logic [11:0] L_FL0  = 12'b000_000_000_000;

  logic        clk;
  logic        reset;
  logic        fault;
  logic [3:0]  sensor;
  logic [11:0] light;
  logic [2:0]  act;
  logic        fa;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          rr_cyc [16] = '{11, 12, 20, 24, 32, 40, 44, 52, 60, 64, 84, 104, 124, 144, 164, 200};
  logic [11:0] rr_lt  [16] = '{L_R0G, L_R0Y, L_ALLR, L_R1G, L_R1Y, L_ALLR, L_R3G, L_R3Y, L_ALLR,
                               L_R1G, L_R3G, L_R1G, L_R3G, L_R1G, L_R0G, L_R0G};
  logic [2:0]  rr_act [16] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3,
                               3'd1, 3'd3, 3'd1, 3'd3, 3'd1, 3'd0, 3'd0};

  multi_phase_traffic_ctrl #(
    .N_ROADS   (4),
    .TICK_DIV  (4),
    .GREEN_MIN (3),
    .SEC_GREEN (2),
    .YELLOW    (2),
    .ALL_RED   (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fault        (fault),
    .sensor       (sensor),
    .light_RYG    (light),
    .active_road  (act),
    .fault_active (fa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    sensor = '0;
    fault  = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic test_reset();
    sensor = 4'b1111;
    fault  = 1'b1;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (light !== L_R0G) begin errors++; $display("FAIL reset_light got %b exp %b", light, L_R0G); end
    checks++;
    if (act !== 3'd0) begin errors++; $display("FAIL reset_active got %0d exp 0", act); end
    checks++;
    if (fa !== 1'b0) begin errors++; $display("FAIL reset_fault_active got %b exp 0", fa); end
    sensor = '0;
    fault  = 1'b0;
    reset  = 1'b0;
    cyc    = 0;
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 200; c++) begin
      checks++;
      if ({light, act, fa} !== {L_R0G, 3'd0, 1'b0}) begin
        errors++;
        $display("FAIL idle c=%0d got %b/%0d/%b exp %b/0/0", c, light, act, fa, L_R0G);
      end
      step();
    end
  endtask

  task automatic test_single_demand();
    logic [11:0] el;
    logic [2:0]  ea;
    do_reset();
    for (int c = 0; c <= 48; c++) begin
      if (c < 12)      begin el = L_R0G;  ea = 3'd0; end
      else if (c < 20) begin el = L_R0Y;  ea = 3'd0; end
      else if (c < 24) begin el = L_ALLR; ea = 3'd0; end
      else if (c < 32) begin el = L_R2G;  ea = 3'd2; end
      else if (c < 40) begin el = 12'b100_010_100_100; ea = 3'd2; end
      else if (c < 44) begin el = L_ALLR; ea = 3'd2; end
      else             begin el = L_R0G;  ea = 3'd0; end
      checks++;
      if ({light, act} !== {el, ea}) begin
        errors++;
        $display("FAIL single_demand c=%0d got %b/%0d exp %b/%0d", c, light, act, el, ea);
      end
      sensor = (c == 5) ? 4'b0100 : 4'b0000;
      step();
    end
    sensor = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      for (int k = 0; k < 16; k++) begin
        if (rr_cyc[k] == c) begin
          checks++;
          if ({light, act} !== {rr_lt[k], rr_act[k]}) begin
            errors++;
            $display("FAIL round_robin c=%0d got %b/%0d exp %b/%0d", c, light, act, rr_lt[k], rr_act[k]);
          end
        end
      end
      if (c >= 12 && c < 164) begin
        checks++;
        if (light[2:0] === 3'b001) begin
          errors++;
          $display("FAIL rr_road0_green c=%0d got %b exp not 001", c, light[2:0]);
        end
      end
      sensor = (c < 104) ? 4'b1010 : 4'b0000;
      step();
    end
    sensor = '0;
  endtask

  task automatic test_fault();
    logic [11:0] el;
    logic [2:0]  ea;
    logic        ef;
    do_reset();
    for (int c = 0; c <= 80; c++) begin
      ef = 1'b0;
      ea = 3'd0;
      if (c < 12)      el = L_R0G;
      else if (c < 20) el = L_R0Y;
      else if (c < 24) el = L_ALLR;
      else if (c < 29) begin el = L_R3G; ea = 3'd3; end
      else if (c < 47) begin el = (((c - 29) / 4) % 2 == 0) ? L_FL1 : L_FL0; ef = 1'b1; end
      else if (c < 51) el = L_ALLR;
      else if (c < 63) el = L_R0G;
      else if (c < 71) el = L_R0Y;
      else if (c < 75) el = L_ALLR;
      else             begin el = L_R2G; ea = 3'd2; end
      checks++;
      if ({light, act, fa} !== {el, ea, ef}) begin
        errors++;
        $display("FAIL fault_flash c=%0d got %b/%0d/%b exp %b/%0d/%b", c, light, act, fa, el, ea, ef);
      end
      sensor = (c == 5) ? 4'b1000 : ((c == 25) ? 4'b0100 : 4'b0000);
      fault  = (c >= 26 && c < 44);
      step();
    end
    sensor = '0;
    fault  = 1'b0;
  endtask

  task automatic test_fault_priority();
    logic [11:0] el;
    logic        ef;
    do_reset();
    for (int c = 0; c <= 41; c++) begin
      ef = 1'b0;
      if (c < 12)       el = L_R0G;
      else if (c < 20)  el = L_R0Y;
      else if (c < 24)  begin el = L_FL1; ef = 1'b1; end
      else if (c == 24) begin el = L_FL0; ef = 1'b1; end
      else if (c < 29)  el = L_ALLR;
      else if (c < 41)  el = L_R0G;
      else              el = L_R0Y;
      checks++;
      if ({light, act, fa} !== {el, 3'd0, ef}) begin
        errors++;
        $display("FAIL fault_priority c=%0d got %b/%0d/%b exp %b/0/%b", c, light, act, fa, el, ef);
      end
      sensor = (c == 5) ? 4'b0100 : 4'b0000;
      fault  = (c >= 17 && c < 22);
      step();
    end
    sensor = '0;
    fault  = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      sensor = (c == 5) ? 4'b0100 : 4'b0000;
      step();
    end
    checks++;
    if (light !== L_R0Y) begin errors++; $display("FAIL mid_pre_reset got %b exp %b", light, L_R0Y); end
    reset = 1'b1;
    #1;
    checks++;
    if ({light, act, fa} !== {L_R0G, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got %b/%0d/%b exp %b/0/0", light, act, fa, L_R0G);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    cyc   = 0;
    for (int c = 0; c <= 12; c++) begin
      checks++;
      if (light !== ((c < 12) ? L_R0G : L_R0Y)) begin
        errors++;
        $display("FAIL mid_restart c=%0d got %b exp %b", c, light, (c < 12) ? L_R0G : L_R0Y);
      end
      sensor = (c == 0) ? 4'b0010 : 4'b0000;
      step();
    end
    sensor = '0;
  endtask

  task automatic test_back_to_back();
    logic [11:0] el;
    logic [2:0]  ea;
    do_reset();
    // Second sensor[1] pulse reaches the synchroniser output on the last all-red cycle.
    for (int c = 0; c <= 48; c++) begin
      if (c < 12)      begin el = L_R0G;  ea = 3'd0; end
      else if (c < 20) begin el = L_R0Y;  ea = 3'd0; end
      else if (c < 24) begin el = L_ALLR; ea = 3'd0; end
      else if (c < 32) begin el = L_R1G;  ea = 3'd1; end
      else if (c < 40) begin el = L_R1Y;  ea = 3'd1; end
      else if (c < 44) begin el = L_ALLR; ea = 3'd1; end
      else             begin el = L_R0G;  ea = 3'd0; end
      checks++;
      if ({light, act} !== {el, ea}) begin
        errors++;
        $display("FAIL clear_wins c=%0d got %b/%0d exp %b/%0d", c, light, act, el, ea);
      end
      sensor = (c == 5 || c == 21) ? 4'b0010 : 4'b0000;
      step();
    end
    sensor = '0;
  endtask

  initial begin
    reset  = 1'b1;
    fault  = 1'b0;
    sensor = '0;
    test_reset();
    test_idle();
    test_single_demand();
    test_round_robin();
    test_fault();
    test_fault_priority();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
